icb_cmd_master: RTL and testbench

Single-outstanding ICB initiator that drives the ICB-to-APB bridge register file from a simple host-side request/result handshake. It converts one host request (read or write, address, data, byte mask) into an ICB command and waits for the matching ICB response. It returns read data and error status to the host and guards both phases with a timeout. It sits on the left side of the ICB slave and is the bus master used by the bench, and by any on-chip sequencer, to program CONTROL/KEY, push WDATA, poll STATE and pop RDATA.

---
 rtl/icb_pkg.sv | 46 ++++
 rtl/icb_cmd_master.sv | 183 ++++++++++++++++++
 tb/tb_icb_cmd_master.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icb_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// icb_pkg
// Shared definitions for the ICB-to-APB bridge slice: register map of the
// bridge register file, the command-master FSM state encoding, the host
// request record, and the byte-mask convention used on the ICB write path.
// -----------------------------------------------------------------------------
package icb_pkg;

    // Register map of the ICB slave register file
    localparam logic [31:0] ICB_ADDR_CONTROL = 32'h2000_0000;
    localparam logic [31:0] ICB_ADDR_STATE   = 32'h2000_0008;
    localparam logic [31:0] ICB_ADDR_WDATA   = 32'h2000_0010;
    localparam logic [31:0] ICB_ADDR_RDATA   = 32'h2000_0018;
    localparam logic [31:0] ICB_ADDR_KEY     = 32'h2000_0020;

    // Command-master FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } icb_state_e;

    // One host request as held in the command registers
    typedef struct packed {
        logic        read;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } icb_req_t;

    // Slave write convention: a set mask bit forces that byte to zero.
    function automatic logic [63:0] icb_apply_mask(input logic [63:0] data,
                                                   input logic [7:0]  wmask);
        logic [63:0] r;
        r = data;
        for (int unsigned i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                r[i*8 +: 8] = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icb_cmd_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// icb_cmd_master
// Single-outstanding ICB initiator. Accepts one host request (read/write,
// address, data, byte mask), issues it as an ICB command, waits for the ICB
// response and hands read data / error / timeout status back to the host.
// Both the command and response phases are bounded by TIMEOUT_CYCLES.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : host request handshake (ready only in IDLE)
//   req_read/addr/wdata/wmask : request fields, latched on acceptance
//   res_valid/res_ready : host result handshake (valid only in DONE)
//   res_rdata           : read data (0 for writes and timeouts)
//   res_err             : slave reported icb_rsp_err
//   res_timeout         : transaction aborted by the timer
//   icb_cmd_*           : ICB command channel (master side)
//   icb_rsp_*           : ICB response channel (master side)
// -----------------------------------------------------------------------------
module icb_cmd_master
    import icb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_rdata,
    output logic        res_err,
    output logic        res_timeout,

    output logic        icb_cmd_valid,
    input  logic        icb_cmd_ready,
    output logic        icb_cmd_read,
    output logic [31:0] icb_cmd_addr,
    output logic [63:0] icb_cmd_wdata,
    output logic [7:0]  icb_cmd_wmask,

    input  logic        icb_rsp_valid,
    output logic        icb_rsp_ready,
    input  logic [63:0] icb_rsp_rdata,
    input  logic        icb_rsp_err
);

    // Timer is at least 8 bits wide, wider only if the limit needs it.
    localparam int unsigned TW_MIN = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TW     = (TW_MIN > 8) ? TW_MIN : 8;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    icb_state_e    r_state,       w_state_nxt;
    icb_req_t      r_cmd,         w_cmd_nxt;
    logic [TW-1:0] r_timer,       w_timer_nxt;
    logic [63:0]   r_res_rdata,   w_res_rdata_nxt;
    logic          r_res_err,     w_res_err_nxt;
    logic          r_res_timeout, w_res_timeout_nxt;

    logic          w_timer_hit;

    // The timer counts completed cycles in the current phase; the phase is
    // aborted on the edge that closes cycle number TIMEOUT_CYCLES.
    assign w_timer_hit = (r_timer >= TMO_LAST);

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_timer       <= '0;
            r_res_rdata   <= '0;
            r_res_err     <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd         <= w_cmd_nxt;
            r_timer       <= w_timer_nxt;
            r_res_rdata   <= w_res_rdata_nxt;
            r_res_err     <= w_res_err_nxt;
            r_res_timeout <= w_res_timeout_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_cmd_nxt         = r_cmd;
        w_timer_nxt       = r_timer;
        w_res_rdata_nxt   = r_res_rdata;
        w_res_err_nxt     = r_res_err;
        w_res_timeout_nxt = r_res_timeout;

        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_cmd_nxt.read  = req_read;
                    w_cmd_nxt.addr  = req_addr;
                    w_cmd_nxt.wdata = req_wdata;
                    w_cmd_nxt.wmask = req_wmask;
                    w_timer_nxt     = '0;
                    w_state_nxt     = ST_CMD;
                end
            end

            ST_CMD: begin
                // A handshake on the expiry edge still wins: the slave has
                // taken the command, so its response must be awaited.
                if (icb_cmd_ready) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_RSP;
                end else if (w_timer_hit) begin
                    w_res_rdata_nxt   = '0;
                    w_res_err_nxt     = 1'b0;
                    w_res_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_DONE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            ST_RSP: begin
                if (icb_rsp_valid) begin
                    w_res_rdata_nxt   = r_cmd.read ? icb_rsp_rdata : '0;
                    w_res_err_nxt     = icb_rsp_err;
                    w_res_timeout_nxt = 1'b0;
                    w_state_nxt       = ST_DONE;
                end else if (w_timer_hit) begin
                    w_res_rdata_nxt   = '0;
                    w_res_err_nxt     = 1'b0;
                    w_res_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_DONE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            ST_DONE: begin
                if (res_ready) begin
                    w_res_rdata_nxt   = '0;
                    w_res_err_nxt     = 1'b0;
                    w_res_timeout_nxt = 1'b0;
                    w_state_nxt       = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state flops and driven from registers only,
    // so no request or response input reaches an output combinationally.
    // Command fields persist past CMD because the slave derives its error
    // response from them during RSP.
    // ------------------------------------------------------------------
    assign req_ready     = (r_state == ST_IDLE);
    assign icb_cmd_valid = (r_state == ST_CMD);
    assign icb_rsp_ready = (r_state == ST_RSP);
    assign res_valid     = (r_state == ST_DONE);

    assign icb_cmd_read  = r_cmd.read;
    assign icb_cmd_addr  = r_cmd.addr;
    assign icb_cmd_wdata = r_cmd.wdata;
    assign icb_cmd_wmask = r_cmd.wmask;

    assign res_rdata     = r_res_rdata;
    assign res_err       = r_res_err;
    assign res_timeout   = r_res_timeout;

endmodule

// File: tb/tb_icb_cmd_master.sv
`timescale 1ns/1ps
module tb_icb_cmd_master;
    import icb_pkg::*;

    localparam int unsigned TMO = 16;
    localparam logic [63:0] STATE_VAL = 64'h5A;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_read;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        res_valid, res_ready;
    logic [63:0] res_rdata;
    logic        res_err, res_timeout;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [63:0] icb_cmd_wdata;
    logic [7:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready;
    logic [63:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    icb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .res_valid(res_valid), .res_ready(res_ready), .res_rdata(res_rdata),
        .res_err(res_err), .res_timeout(res_timeout),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    // CONTROL/KEY read-write, STATE read-only, WDATA write-only (never full),
    // RDATA read-only with its FIFO always empty (command never accepted).
    logic [63:0] s_control, s_key, s_rdata_q;
    logic        s_pending, s_hold, s_flush, s_err;

    always_comb begin
        s_err = 1'b1;
        if (icb_cmd_addr == ICB_ADDR_CONTROL || icb_cmd_addr == ICB_ADDR_KEY) s_err = 1'b0;
        if (icb_cmd_addr == ICB_ADDR_STATE && icb_cmd_read)  s_err = 1'b0;
        if (icb_cmd_addr == ICB_ADDR_RDATA && icb_cmd_read)  s_err = 1'b0;
        if (icb_cmd_addr == ICB_ADDR_WDATA && !icb_cmd_read) s_err = 1'b0;
    end

    assign icb_cmd_ready = !s_pending && !(icb_cmd_read && icb_cmd_addr == ICB_ADDR_RDATA);
    assign icb_rsp_valid = s_pending && !s_hold;
    assign icb_rsp_err   = s_err;
    assign icb_rsp_rdata = s_rdata_q;

    always @(posedge clk) begin
        if (rst) begin
            s_pending <= 1'b0;
            s_control <= '0;
            s_key     <= '0;
            s_rdata_q <= '0;
        end else if (s_flush) begin
            s_pending <= 1'b0;
        end else if (icb_cmd_valid && icb_cmd_ready) begin
            s_pending <= 1'b1;
            s_rdata_q <= '0;
            if (icb_cmd_read) begin
                if (icb_cmd_addr == ICB_ADDR_CONTROL) s_rdata_q <= s_control;
                if (icb_cmd_addr == ICB_ADDR_KEY)     s_rdata_q <= s_key;
                if (icb_cmd_addr == ICB_ADDR_STATE)   s_rdata_q <= STATE_VAL;
            end else begin
                if (icb_cmd_addr == ICB_ADDR_CONTROL) s_control <= icb_apply_mask(icb_cmd_wdata, icb_cmd_wmask);
                if (icb_cmd_addr == ICB_ADDR_KEY)     s_key     <= icb_apply_mask(icb_cmd_wdata, icb_cmd_wmask);
            end
        end else if (icb_rsp_valid && icb_rsp_ready) begin
            s_pending <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        logic        read;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_cmd_cyc;
        int          exp_rsp_cyc;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t mon_e;
    int   cnt_cmd = 0;
    int   cnt_rsp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on each result handshake.
    always @(negedge clk) begin
        if (rst) begin
            cnt_cmd = 0;
            cnt_rsp = 0;
        end else begin
            if (icb_cmd_valid) cnt_cmd++;
            if (icb_rsp_ready) cnt_rsp++;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("res_rdata",   res_rdata,   mon_e.exp_rdata);
                    chk("res_err",     res_err,     mon_e.exp_err);
                    chk("res_timeout", res_timeout, mon_e.exp_tmo);
                    chk("cmd_cycles",  cnt_cmd,     mon_e.exp_cmd_cyc);
                    chk("rsp_cycles",  cnt_rsp,     mon_e.exp_rsp_cyc);
                end
                cnt_cmd = 0;
                cnt_rsp = 0;
            end
        end
    end

    task automatic do_req(input vec_t v, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", req_ready, 1'b1);
            return;
        end
        req_valid = 1'b1;
        req_read  = v.read;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wmask = v.wmask;
        if (push) sb.push_back(v);
        @(negedge clk);
        req_valid = 1'b0;
        chk("cmd_valid_t1", icb_cmd_valid, 1'b1);
        chk("cmd_addr",     icb_cmd_addr,  v.addr);
        chk("cmd_read",     icb_cmd_read,  v.read);
        chk("cmd_wdata",    icb_cmd_wdata, v.wdata);
        chk("cmd_wmask",    icb_cmd_wmask, v.wmask);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_wait", 64'd0, 64'd1);
            sb.delete();
        end
    endtask

    vec_t tbl[12];
    vec_t hv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        //         rd    addr              wdata                   wmask  exp_rdata               err   tmo  cmd  rsp
        tbl[0]  = '{1'b0, ICB_ADDR_CONTROL, 64'h1,                  8'h00, 64'h0,                  1'b0, 1'b0, 1,   1};
        tbl[1]  = '{1'b1, ICB_ADDR_CONTROL, 64'h0,                  8'h00, 64'h1,                  1'b0, 1'b0, 1,   1};
        tbl[2]  = '{1'b0, ICB_ADDR_KEY,     64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0,                  1'b0, 1'b0, 1,   1};
        tbl[3]  = '{1'b1, ICB_ADDR_KEY,     64'h0,                  8'h00, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 1,   1};
        tbl[4]  = '{1'b0, ICB_ADDR_STATE,   64'h5,                  8'h00, 64'h0,                  1'b1, 1'b0, 1,   1};
        tbl[5]  = '{1'b1, ICB_ADDR_STATE,   64'h0,                  8'h00, 64'h5A,                 1'b0, 1'b0, 1,   1};
        tbl[6]  = '{1'b0, ICB_ADDR_WDATA,   64'h1234,               8'h00, 64'h0,                  1'b0, 1'b0, 1,   1};
        tbl[7]  = '{1'b1, 32'h2000_0030,    64'h0,                  8'h00, 64'h0,                  1'b1, 1'b0, 1,   1};
        tbl[8]  = '{1'b1, ICB_ADDR_RDATA,   64'h0,                  8'h00, 64'h0,                  1'b0, 1'b1, 16,  0};
        tbl[9]  = '{1'b0, ICB_ADDR_CONTROL, 64'h1122_3344_5566_7788, 8'hF0, 64'h0,                  1'b0, 1'b0, 1,   1};
        tbl[10] = '{1'b1, ICB_ADDR_CONTROL, 64'h0,                  8'h00, 64'h0000_0000_5566_7788, 1'b0, 1'b0, 1,   1};
        tbl[11] = '{1'b1, ICB_ADDR_WDATA,   64'h0,                  8'h00, 64'h0,                  1'b1, 1'b0, 1,   1};

        rst = 1'b1;
        req_valid = 1'b0; req_read = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        res_ready = 1'b1; s_hold = 1'b0; s_flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready",   req_ready,     1'b1);
        chk("rst_cmd_valid",   icb_cmd_valid, 1'b0);
        chk("rst_rsp_ready",   icb_rsp_ready, 1'b0);
        chk("rst_res_valid",   res_valid,     1'b0);
        chk("rst_res_err",     res_err,       1'b0);
        chk("rst_res_timeout", res_timeout,   1'b0);
        chk("rst_res_rdata",   res_rdata,     64'h0);
        chk("rst_cmd_addr",    icb_cmd_addr,  32'h0);

        for (int i = 0; i < 12; i++) begin
            do_req(tbl[i], 1'b1);
            wait_done();
        end

        // Host stalls the result for 10 cycles while another request waits.
        res_ready = 1'b0;
        hv = '{1'b1, ICB_ADDR_STATE, 64'h0, 8'h00, 64'h5A, 1'b0, 1'b0, 1, 1};
        do_req(hv, 1'b1);
        begin
            int n = 0;
            while (!res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("hold_res_valid_seen", res_valid, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                req_valid = 1'b1; req_read = 1'b0; req_addr = ICB_ADDR_KEY;
                req_wdata = 64'hDEAD; req_wmask = 8'h00;
            end
            if (c == 8) req_valid = 1'b0;
            @(negedge clk);
            chk("hold_res_valid", res_valid,     1'b1);
            chk("hold_res_rdata", res_rdata,     64'h5A);
            chk("hold_res_err",   res_err,       1'b0);
            chk("hold_req_ready", req_ready,     1'b0);
            chk("hold_cmd_valid", icb_cmd_valid, 1'b0);
        end
        res_ready = 1'b1;
        wait_done();

        // Response withheld: RSP-phase timeout, then a late response is ignored.
        s_hold = 1'b1;
        hv = '{1'b0, ICB_ADDR_KEY, 64'h0, 8'h00, 64'h0, 1'b0, 1'b1, 1, 16};
        do_req(hv, 1'b1);
        wait_done();
        s_hold = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("late_rsp_res_valid", res_valid,     1'b0);
            chk("late_rsp_rsp_ready", icb_rsp_ready, 1'b0);
            chk("late_rsp_req_ready", req_ready,     1'b1);
        end
        s_flush = 1'b1;
        @(negedge clk);
        s_flush = 1'b0;

        // Reset in the cycle after the command handshake.
        hv = '{1'b0, ICB_ADDR_CONTROL, 64'h7, 8'h00, 64'h0, 1'b0, 1'b0, 1, 1};
        do_req(hv, 1'b0);
        @(negedge clk);
        chk("mid_rsp_ready", icb_rsp_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_cmd_valid", icb_cmd_valid, 1'b0);
        chk("mid_rst_rsp_ready", icb_rsp_ready, 1'b0);
        chk("mid_rst_res_valid", res_valid,     1'b0);
        chk("mid_rst_req_ready", req_ready,     1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_res_valid", res_valid,     1'b0);
            chk("post_rst_cmd_valid", icb_cmd_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
